cordic_hyp_sequencer: RTL
=========================

# cordic_hyp_sequencer

Control FSM for the iterative hyperbolic CORDIC datapath. It accepts a start request and sequences the per-cycle micro-rotation shift index, which also drives the atanh ROM `which_angle`. It applies the mandatory hyperbolic repeat iterations (shift 4, 13, 40, …) and produces the per-step rotation direction from datapath sign feedback. It sits between the peripheral register interface and the x/y/z iteration registers.

## Interface
- `FIXED_WIDTH`, default 16: datapath word width. Not used internally; kept for parameter-list parity with the datapath.
- `ITERATIONS`, default 9:
  - `ITERATIONS-1` is the highest shift index issued (`MAX_SHIFT`).
  - `SW = $clog2(ITERATIONS)` is the shift port width.
  - Derived `N_STEPS` = `MAX_SHIFT` + count of repeat indices (4, 13, 40, …) ≤ `MAX_SHIFT`.
  - With the default, `N_STEPS` = 9.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `start`  in  1  request a new operation; sampled only in IDLE
- `mode`  in  1  0 = rotation, 1 = vectoring; latched on accepted `start`
- `abort`  in  1  cancel the operation in progress
- `z_neg`  in  1  sign bit of the datapath z register
- `y_neg`  in  1  sign bit of the datapath y register
- `busy`  out  1  high in LOAD, ITER and DONE
- `load`  out  1  one-cycle strobe: datapath loads initial x/y/z
- `step_en`  out  1  datapath performs one micro-rotation this cycle
- `shift`  out  SW  current shift index; drives ROM `which_angle` and the datapath shifters
- `dir_sub`  out  1  1: d = −1 (x/y add-subtract swapped, z += angle); 0: d = +1
- `done`  out  1  one-cycle completion pulse

## Operation
States: IDLE, LOAD, ITER, DONE.
- **IDLE**
  - `start`=1 → LOAD.
  - On the same edge: latch `mode`, set `shift`=1, clear `rep_done`, set `next_rep`=4.
- **LOAD**
  - `load`=1 → ITER.
  - `shift` already = 1, so the ROM output is valid before the first step.
- **ITER**
  - `step_en`=1 every cycle.
  - Shift advance, evaluated at each edge:
    - If `shift`==`next_rep` and `rep_done`=0: hold `shift`, set `rep_done`=1.
    - Else if `shift`==`next_rep` and `rep_done`=1: `shift`+1, clear `rep_done`, `next_rep` ← 3·`next_rep`+1.
    - Else: `shift`+1.
  - `next_rep` is held in a register of width SW+2, so the 3k+1 update never wraps.
  - Leave ITER after exactly `N_STEPS` step cycles: the last step has `shift`==`MAX_SHIFT` with no pending repeat. Next state is DONE.
  - `shift` never exceeds `MAX_SHIFT`.
- **DONE**
  - `done`=1 for one cycle → IDLE.
  - `shift` ← 0.
- **Direction** (combinational; meaningful only while `step_en`=1):
  - Rotation: `dir_sub` = `z_neg`.
  - Vectoring: `dir_sub` = ~`y_neg`, since x is positive in the hyperbolic vectoring domain.
- **Default shift sequence** (`ITERATIONS`=9): 1, 2, 3, 4, 4, 5, 6, 7, 8.
- **Boundary rules**
  - `start` while `busy`=1: ignored, including `start` in the DONE cycle.
  - Back-to-back operation: `start` in the first IDLE cycle after DONE is accepted.
  - `abort`=1 in LOAD, ITER or DONE: next state IDLE, `shift` ← 0, no `done` pulse. In the DONE cycle itself the `done` pulse is still visible that cycle.
  - `abort` in IDLE: no effect. `abort` and `start` together in IDLE: `abort` wins, nothing is accepted.
  - `mode` changes mid-operation: no effect; the latched value is used.

## Timing
- **Reset** (`rst_n`=0 at an edge):
  - State IDLE.
  - `busy`=0, `load`=0, `step_en`=0, `done`=0, `shift`=0.
  - Latched mode = 0, `rep_done`=0, `next_rep`=4.
  - `dir_sub` follows the combinational rule with mode 0, i.e. `dir_sub` = `z_neg`.
  - Reset mid-operation aborts immediately; no `done`.
- **Cycle map** (`start` sampled at edge 0):
  - LOAD: cycle 1.
  - ITER: cycles 2 … `N_STEPS`+1.
  - DONE: cycle `N_STEPS`+2.
  - With the default this is DONE at cycle 11; `busy` is high for `N_STEPS`+2 = 11 cycles.
- **Registered outputs**: `busy`, `load`, `step_en` and `done` are decoded from registered state only.
- **`shift` validity**: `shift` is registered and changes only at edges. It is stable for the whole cycle in which `step_en`=1.
- **`dir_sub`**: combinational from `z_neg`/`y_neg` plus the latched mode. The datapath provides these sign bits from its registers, so there is no combinational loop.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles with `start`=1 → all outputs 0 and `shift`=0. After release, with `start`=0, the block stays in IDLE.
- **Rotation, default parameters**: `start`=1, `mode`=0 → `load` at cycle 1; `step_en` at cycles 2–10 with `shift` = 1, 2, 3, 4, 4, 5, 6, 7, 8; `done` at cycle 11; `busy` high for cycles 1–11. Drive `z_neg`=1 → `dir_sub`=1; `z_neg`=0 → `dir_sub`=0.
- **Vectoring plus mode latch**: start with `mode`=1, then drive `mode`=0 at cycle 3 → `dir_sub` = ~`y_neg` for every step (`y_neg`=0 → `dir_sub`=1).
- **Ignored and back-to-back start**:
  - Pulse `start` at cycles 4 and 11 → the sequence is unchanged and `done` comes only at cycle 11.
  - `start` at cycle 12 → new `load` at cycle 13.
- **Abort**:
  - `abort` at cycle 6 → IDLE at cycle 7 with `shift`=0, `busy`=0 and no `done`.
  - Simultaneous `abort` + `start` in IDLE → no `load`.
- **Repeat at 13**: `ITERATIONS`=16 → shifts 1..4, 4, 5..13, 13, 14, 15 (`N_STEPS`=17), `done` at cycle 19, and `shift` never exceeds 15.

Source files
------------

// File: rtl/cordic_hyp_sequencer.sv
// Control FSM for the iterative hyperbolic CORDIC datapath.
// Issues the micro-rotation shift index, including the mandatory hyperbolic
// repeat steps (4, 13, 40, ...), and derives the rotation direction from the
// datapath sign feedback.
module cordic_hyp_sequencer #(
    parameter int FIXED_WIDTH = 16,
    parameter int ITERATIONS  = 9,
    localparam int SW         = $clog2(ITERATIONS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    input  logic          z_neg,
    input  logic          y_neg,
    output logic          busy,
    output logic          load,
    output logic          step_en,
    output logic [SW-1:0] shift,
    output logic          dir_sub,
    output logic          done
);

    // FIXED_WIDTH only mirrors the datapath parameter list.
    if ((FIXED_WIDTH < 1) || (ITERATIONS < 2)) begin : g_bad_param
        $error("cordic_hyp_sequencer: FIXED_WIDTH must be >= 1 and ITERATIONS >= 2");
    end

    localparam int MAX_SHIFT = ITERATIONS - 1;
    localparam int RW        = SW + 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StIter,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [SW-1:0]   r_shift;
    logic [SW-1:0]   w_shift_next;
    logic            r_mode;
    logic            w_mode_next;
    logic            r_rep_done;
    logic            w_rep_done_next;
    // Two extra bits so 3k+1 never wraps for any k <= MAX_SHIFT.
    logic [RW-1:0]   r_next_rep;
    logic [RW-1:0]   w_next_rep_next;

    logic            w_at_rep;
    logic            w_rep_pending;
    logic            w_last_step;
    logic [RW-1:0]   w_next_rep_x3p1;

    assign w_at_rep        = ({2'b00, r_shift} == r_next_rep);
    assign w_rep_pending   = w_at_rep && !r_rep_done;
    // Final step: top shift index with its repeat (if any) already issued.
    assign w_last_step     = (r_shift == SW'(MAX_SHIFT)) && !w_rep_pending;
    assign w_next_rep_x3p1 = r_next_rep + {r_next_rep[RW-2:0], 1'b0} + RW'(1);

    // State and sequencing registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_mode     <= 1'b0;
            r_rep_done <= 1'b0;
            r_next_rep <= RW'(4);
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_mode     <= w_mode_next;
            r_rep_done <= w_rep_done_next;
            r_next_rep <= w_next_rep_next;
        end
    end

    // Next-state and shift-advance logic.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_mode_next     = r_mode;
        w_rep_done_next = r_rep_done;
        w_next_rep_next = r_next_rep;
        unique case (r_state)
            StIdle: begin
                // abort beats start in IDLE.
                if (start && !abort) begin
                    w_state_next    = StLoad;
                    w_mode_next     = mode;
                    w_shift_next    = SW'(1);
                    w_rep_done_next = 1'b0;
                    w_next_rep_next = RW'(4);
                end
            end
            StLoad: begin
                if (abort) begin
                    w_state_next = StIdle;
                    w_shift_next = '0;
                end else begin
                    w_state_next = StIter;
                end
            end
            StIter: begin
                if (abort) begin
                    w_state_next = StIdle;
                    w_shift_next = '0;
                end else if (w_last_step) begin
                    // Hold the final index so shift never exceeds MAX_SHIFT.
                    w_state_next = StDone;
                end else if (w_rep_pending) begin
                    w_rep_done_next = 1'b1;
                end else if (w_at_rep) begin
                    w_shift_next    = r_shift + SW'(1);
                    w_rep_done_next = 1'b0;
                    w_next_rep_next = w_next_rep_x3p1;
                end else begin
                    w_shift_next = r_shift + SW'(1);
                end
            end
            StDone: begin
                w_state_next = StIdle;
                w_shift_next = '0;
            end
            default: begin
                w_state_next = StIdle;
                w_shift_next = '0;
            end
        endcase
    end

    assign busy    = (r_state != StIdle);
    assign load    = (r_state == StLoad);
    assign step_en = (r_state == StIter);
    assign done    = (r_state == StDone);
    assign shift   = r_shift;

    // In vectoring x is positive, so the direction only depends on the sign of y.
    assign dir_sub = r_mode ? ~y_neg : z_neg;

endmodule
